// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore-style control sequencer for a shared-memory,
// multi-cycle ALU datapath (FETCH/DECODE then one of the lw, sw, R-type,
// beq, j or addi execution paths).
//
// Optional feature: define MULTICYCLE_PERF_EN to build the cycle and
// retired-instruction performance counters. Without it both counter
// outputs are tied to zero and no counter registers exist.
//
// Control outputs are registered alongside the state register. Each one is
// loaded from the decode of the next state, so it always matches the
// current state. Reset loads the FETCH decode asynchronously. The FETCH
// handshake strobes (ir_write and the fetch part of pc_write) are qualified
// with the live mem_ready. The DECODE illegal flag is qualified with the
// live op_code. Both are asynchronous qualifiers, so they cannot be held in
// a register.

module multicycle_ctrl #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        op_code,
  input  logic              mem_ready,
  input  logic              zero,
  output logic              pc_write,
  output logic              pc_write_cond,
  output logic              i_or_d,
  output logic              mem_req,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic              mem_to_reg,
  output logic              reg_dst,
  output logic              reg_write,
  output logic              alu_src_a,
  output logic              illegal,
  output logic [1:0]        alu_src_b,
  output logic [3:0]        alu_op,
  output logic [1:0]        pc_source,
  output logic [3:0]        state,
  output logic [PERF_W-1:0] cycle_count,
  output logic [PERF_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_FUNCT = 4'b0010;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // Opcodes the sequencer knows how to execute; all others are illegal.
  function automatic logic opcode_known(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

  // Per-state control decode. Fields not set for a state stay 0, which also
  // covers the unused codes 12-15. ir_write and the FETCH pc_write are not
  // part of this table because they depend on mem_ready.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        c.mem_req  = 1'b1;
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b00;
        c.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = 2'b00;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALU_ADD;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t state_q;
  state_t state_nxt;
  ctrl_t  ctrl_q;
  logic   fetch_ack;

  // The zero flag qualifies pc_write_cond inside the datapath, not here.
  logic   unused_zero;
  assign unused_zero = zero;

  // Next-state selection; op_code matters only in DECODE/MEMADR and
  // mem_ready only in the three memory-access states.
  always_comb begin
    state_nxt = S_FETCH;
    case (state_q)
      S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_code)
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          OP_ADDI:      state_nxt = S_ADDIEX;
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR: state_nxt = (op_code == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_nxt = S_FETCH;
      S_MEMWR:  state_nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_nxt = S_ALUWB;
      S_ALUWB:  state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
      S_JUMP:   state_nxt = S_FETCH;
      S_ADDIEX: state_nxt = S_ADDIWB;
      S_ADDIWB: state_nxt = S_FETCH;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // State register plus registered control decode of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode_ctrl(S_FETCH);
    end else begin
      state_q <= state_nxt;
      ctrl_q  <= decode_ctrl(state_nxt);
    end
  end

  // Instruction fetch completes in the FETCH cycle where memory answers;
  // reset suppresses it so nothing is latched while rst_n is low.
  assign fetch_ack = rst_n && (state_q == S_FETCH) && mem_ready;

  assign state         = state_q;
  assign pc_write      = ctrl_q.pc_write | fetch_ack;
  assign ir_write      = fetch_ack;
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign i_or_d        = ctrl_q.i_or_d;
  assign mem_req       = ctrl_q.mem_req;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign reg_dst       = ctrl_q.reg_dst;
  assign reg_write     = ctrl_q.reg_write;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign alu_op        = ctrl_q.alu_op;
  assign pc_source     = ctrl_q.pc_source;
  // An unknown opcode is flagged for the single DECODE cycle; the FSM then
  // returns to FETCH without visiting any write state.
  assign illegal       = (state_q == S_DECODE) && !opcode_known(op_code);

`ifdef MULTICYCLE_PERF_EN
  logic [PERF_W-1:0] cycle_q;
  logic [PERF_W-1:0] instr_q;
  logic              retire;

  // An instruction retires when its last state hands back to FETCH;
  // the DECODE->FETCH path of an illegal opcode is deliberately excluded.
  assign retire = (state_nxt == S_FETCH) &&
                  ((state_q == S_MEMWB)  || (state_q == S_MEMWR)  ||
                   (state_q == S_ALUWB)  || (state_q == S_BRANCH) ||
                   (state_q == S_JUMP)   || (state_q == S_ADDIWB));

  // Free-running cycle counter and retired-instruction counter, both wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_q + PERF_W'(1);
      if (retire) begin
        instr_q <= instr_q + PERF_W'(1);
      end
    end
  end

  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: PERF_W, default 32, width of the performance counters.
REQ-002 Port: clk  input  1  rising-edge system clock.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: op_code  input  6  opcode field of the instruction register.
REQ-005 Port: mem_ready  input  1  memory has completed the current request this cycle.
REQ-006 Port: zero  input  1  ALU zero flag.
REQ-007 Ports, 1-bit outputs: pc_write, pc_write_cond, i_or_d, mem_req, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal.
REQ-008 Ports, multi-bit outputs: alu_src_b  output  2  ALU B select; alu_op  output  4  command to the ALU control unit; pc_source  output  2  next-PC select; state  output  4  current state.
REQ-009 Ports: cycle_count  output  PERF_W  cycles since reset; instr_count  output  PERF_W  instructions retired.

Function
REQ-010 The block SHALL be a Moore FSM sequencing a shared-memory, multi-cycle ALU datapath; all control outputs decode from the state register only.
REQ-011 State encoding SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
REQ-012 FETCH: mem_req=1, mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=0000 (add); ir_write=1 and pc_write=1 only in the cycle mem_ready=1; go to DECODE on mem_ready, else hold.
REQ-013 DECODE: alu_src_a=0, alu_src_b=11, alu_op=0000 (branch-target add). Next state by op_code: 000000->EXEC, 100011 or 101011->MEMADR, 000100->BRANCH, 000010->JUMP, 001000->ADDIEX, any other->FETCH.
REQ-014 An undefined opcode in DECODE SHALL assert illegal for exactly that one cycle; no register or memory write occurs for that instruction.
REQ-015 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=0000; go to MEMRD for 100011, else MEMWR.
REQ-016 MEMRD: mem_req=1, mem_read=1, i_or_d=1; hold until mem_ready, then MEMWB.
REQ-017 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; then FETCH.
REQ-018 MEMWR: mem_req=1, mem_write=1, i_or_d=1; hold until mem_ready, then FETCH.
REQ-019 EXEC: alu_src_a=1, alu_src_b=00, alu_op=0010 (decode funct); then ALUWB.
REQ-020 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
REQ-021 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=0001 (sub), pc_write_cond=1, pc_source=01; then FETCH.
REQ-022 JUMP: pc_write=1, pc_source=10; then FETCH.
REQ-023 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=0000; then ADDIWB. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
REQ-024 Outputs not listed for a state SHALL be 0; state codes 12-15 SHALL transition to FETCH with all controls 0.
REQ-025 op_code SHALL be sampled only in DECODE and MEMADR; mem_ready SHALL be ignored outside FETCH, MEMRD and MEMWR.
REQ-026 Cycle counts per instruction at zero memory wait: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4; each mem_ready-low cycle in a memory state adds one cycle.

Reset
REQ-027 Asserting rst_n low SHALL force state=FETCH and clear both counters immediately, including in the middle of a memory wait.
REQ-028 During reset, all control outputs SHALL equal the FETCH decode, with ir_write=0 and pc_write=0.
REQ-029 The first FETCH SHALL begin at the first rising clk edge after rst_n rises.

Configuration
REQ-030 When macro MULTICYCLE_PERF_EN is defined, cycle_count SHALL increment every cycle and instr_count SHALL increment on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, JUMP or ADDIWB (an illegal opcode is not counted); both counters wrap modulo 2^PERF_W.
REQ-031 When MULTICYCLE_PERF_EN is not defined, both counters SHALL be constant 0 and SHALL have no registers.

Verification
REQ-032 Reset release, op_code=000000, mem_ready=1 -> states 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; instr_count=1.
REQ-033 lw (100011) with mem_ready low for 2 cycles in MEMRD -> MEMRD lasts 3 cycles; total 7 cycles; mem_to_reg=1 in MEMWB.
REQ-034 beq (000100) -> BRANCH asserts pc_write_cond=1, pc_source=01, alu_op=0001; 3 cycles total.
REQ-035 op_code=111111 in DECODE -> illegal=1 for one cycle, next state FETCH, no reg_write/mem_write, instr_count unchanged.
REQ-036 rst_n pulsed low during a MEMWR wait -> state=0 and counters=0 asynchronously; mem_write drops before the next clk edge.
REQ-037 With MULTICYCLE_PERF_EN, PERF_W=4, 17 free-running cycles -> cycle_count wraps to 1; without the macro, both counters read 0.
